// File: rtl/unlock_sequencer.sv
// Key-entry sequencer: collects KEY_LEN bytes, compares them against KEY and
// drives an unlock handshake toward the lock register, with failure backoff and lockout.
module unlock_sequencer #(
  parameter int                   KEY_LEN     = 4,
  parameter logic [KEY_LEN*8-1:0] KEY         = 32'hA55AC33C,
  parameter int                   MAX_FAIL    = 3,
  parameter int                   FAIL_DELAY  = 16,
  parameter int                   ACK_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_valid,
  input  logic [7:0] key_byte,
  output logic       key_ready,
  input  logic       locked,
  output logic       unlock,
  output logic [3:0] fail_cnt,
  output logic       lockout
);

  localparam int IW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

  typedef enum logic [2:0] {IDLE, COLLECT, UNLOCK, FAIL_WAIT, LOCKOUT} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          mism;
  logic [7:0]    dly;
  logic [7:0]    tmo;

  // Key split into bytes, index 0 is the first byte entered (MSBs of KEY).
  logic [7:0] key_bytes [KEY_LEN];
  for (genvar g = 0; g < KEY_LEN; g++) begin : g_key
    assign key_bytes[g] = KEY[8*(KEY_LEN-1-g) +: 8];
  end

  logic       accept;
  logic       mism_nxt;
  logic [3:0] fail_nxt;
  logic       fail_lock;
  state_t     fail_state;

  assign key_ready  = (state == IDLE) || (state == COLLECT);
  assign accept     = key_valid && key_ready;
  assign mism_nxt   = mism | (key_byte != key_bytes[idx]);
  assign fail_nxt   = (fail_cnt == 4'hF) ? 4'hF : fail_cnt + 4'd1;
  assign fail_lock  = ({28'd0, fail_nxt} >= MAX_FAIL);
  assign fail_state = fail_lock ? LOCKOUT : FAIL_WAIT;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state    <= IDLE;
      idx      <= '0;
      mism     <= 1'b0;
      dly      <= 8'd0;
      tmo      <= 8'd0;
      unlock   <= 1'b0;
      fail_cnt <= 4'd0;
      lockout  <= 1'b0;
    end else begin
      case (state)
        IDLE, COLLECT: begin
          if (accept) begin
            if (idx == IW'(KEY_LEN-1)) begin
              idx  <= '0;
              mism <= 1'b0;
              if (!mism_nxt) begin
                state  <= UNLOCK;
                unlock <= 1'b1;
                tmo    <= 8'd0;
              end else begin
                state    <= fail_state;
                lockout  <= fail_lock;
                fail_cnt <= fail_nxt;
                dly      <= 8'd0;
              end
            end else begin
              // Mismatches only mark the attempt; every byte is still consumed.
              idx   <= idx + 1'b1;
              mism  <= mism_nxt;
              state <= COLLECT;
            end
          end
        end
        UNLOCK: begin
          if (!locked) begin
            unlock   <= 1'b0;
            fail_cnt <= 4'd0;
            state    <= IDLE;
          end else if (tmo == 8'(ACK_TIMEOUT-1)) begin
            unlock   <= 1'b0;
            state    <= fail_state;
            lockout  <= fail_lock;
            fail_cnt <= fail_nxt;
            dly      <= 8'd0;
          end else begin
            tmo <= tmo + 8'd1;
          end
        end
        FAIL_WAIT: begin
          if (dly == 8'(FAIL_DELAY-1)) state <= IDLE;
          else dly <= dly + 8'd1;
        end
        LOCKOUT: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unlock_sequencer.sv
// Directed bench for unlock_sequencer: per-cycle vector table plus hand-written
// sequences for timeout, lockout and mid-sequence reset.
module tb_unlock_sequencer;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       key_valid = 1'b0;
  logic [7:0] key_byte = 8'h00;
  logic       key_ready;
  logic       locked = 1'b1;
  logic       unlock;
  logic [3:0] fail_cnt;
  logic       lockout;

  int tests = 0;
  int fails = 0;

  unlock_sequencer dut (
    .clk(clk), .resetn(resetn), .key_valid(key_valid), .key_byte(key_byte),
    .key_ready(key_ready), .locked(locked), .unlock(unlock),
    .fail_cnt(fail_cnt), .lockout(lockout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] b;
    logic       lk;
    logic       r;
    logic       u;
    logic [3:0] f;
    logic       lo;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic v, logic [7:0] b, logic lk,
                              logic r, logic u, logic [3:0] f, logic lo);
    vec_t e;
    e.v = v; e.b = b; e.lk = lk; e.r = r; e.u = u; e.f = f; e.lo = lo;
    tbl.push_back(e);
  endfunction

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One cycle: drive inputs at the falling edge; outputs are stable until the next rise.
  task automatic cyc(logic v, logic [7:0] b, logic lk);
    @(negedge clk);
    key_valid = v;
    key_byte  = b;
    locked    = lk;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn    = 1'b1;
    key_valid = 1'b0;
    locked    = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
  endtask

  task automatic send(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3);
    cyc(1, b0, 1); cyc(1, b1, 1); cyc(1, b2, 1); cyc(1, b3, 1);
  endtask

  task automatic wait_ready(string name);
    int i;
    for (i = 0; i < 40; i++) begin
      cyc(0, 8'h00, 1);
      if (key_ready) break;
    end
    chk({name, ".ready_timeout"}, int'(i < 40), 1);
  endtask

  // Correct key, locked falls two cycles after unlock rises; returns unlock-high count.
  task automatic key_with_ack(output int n);
    n = 0;
    send(8'hA5, 8'h5A, 8'hC3, 8'h3C);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 8'h00, (n >= 2) ? 1'b0 : 1'b1);
      if (unlock) n++;
    end
  endtask

  initial begin
    int  n;
    bit  seen_u, seen_r;

    // Correct key with a two-cycle acknowledge.
    add(1, 8'hA5, 1, 1, 0, 0, 0);
    add(1, 8'h5A, 1, 1, 0, 0, 0);
    add(1, 8'hC3, 1, 1, 0, 0, 0);
    add(1, 8'h3C, 1, 1, 0, 0, 0);
    add(0, 8'h00, 1, 0, 1, 0, 0);
    add(0, 8'h00, 1, 0, 1, 0, 0);
    add(0, 8'h00, 0, 0, 1, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0, 0);
    // Wrong third byte, then bytes offered during the backoff must be dropped.
    add(1, 8'hA5, 1, 1, 0, 0, 0);
    add(1, 8'h5A, 1, 1, 0, 0, 0);
    add(1, 8'h00, 1, 1, 0, 0, 0);
    add(1, 8'h3C, 1, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) add(1, 8'hA5, 1, 0, 0, 1, 0);
    // Correct key with gaps, locked already low: one-cycle unlock, count clears.
    add(1, 8'hA5, 1, 1, 0, 1, 0);
    add(0, 8'h00, 1, 1, 0, 1, 0);
    add(1, 8'h5A, 1, 1, 0, 1, 0);
    add(1, 8'hC3, 1, 1, 0, 1, 0);
    add(0, 8'h00, 1, 1, 0, 1, 0);
    add(1, 8'h3C, 1, 1, 0, 1, 0);
    add(0, 8'h00, 0, 0, 1, 1, 0);
    add(0, 8'h00, 0, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("reset.ready",   int'(key_ready), 1);
    chk("reset.unlock",  int'(unlock),    0);
    chk("reset.fail",    int'(fail_cnt),  0);
    chk("reset.lockout", int'(lockout),   0);
    resetn = 1'b0;

    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].b, tbl[i].lk);
      chk($sformatf("vec%0d.ready", i),   int'(key_ready), int'(tbl[i].r));
      chk($sformatf("vec%0d.unlock", i),  int'(unlock),    int'(tbl[i].u));
      chk($sformatf("vec%0d.fail", i),    int'(fail_cnt),  int'(tbl[i].f));
      chk($sformatf("vec%0d.lockout", i), int'(lockout),   int'(tbl[i].lo));
    end

    // Acknowledge timeout: unlock held exactly 8 cycles, then backoff.
    do_reset();
    send(8'hA5, 8'h5A, 8'hC3, 8'h3C);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 8'h00, 1);
      if (unlock) n++;
      else if (n > 0) break;
    end
    chk("tmo.unlock_cycles", n, 8);
    chk("tmo.fail", int'(fail_cnt), 1);
    chk("tmo.ready_low", int'(key_ready), 0);
    repeat (15) cyc(0, 8'h00, 1);
    chk("tmo.ready_last_wait", int'(key_ready), 0);
    cyc(0, 8'h00, 1);
    chk("tmo.ready_back", int'(key_ready), 1);

    // Three wrong attempts lock the block out permanently.
    do_reset();
    send(8'hA5, 8'h5A, 8'h00, 8'h3C);
    wait_ready("lo1");
    chk("lo1.fail", int'(fail_cnt), 1);
    send(8'hFF, 8'h5A, 8'hC3, 8'h3C);
    wait_ready("lo2");
    chk("lo2.fail", int'(fail_cnt), 2);
    send(8'hA5, 8'h5A, 8'hC3, 8'h3D);
    cyc(0, 8'h00, 1);
    chk("lo3.lockout", int'(lockout), 1);
    chk("lo3.fail", int'(fail_cnt), 3);
    seen_u = 0; seen_r = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1, (i == 0) ? 8'hA5 : (i == 1) ? 8'h5A : (i == 2) ? 8'hC3 : 8'h3C, 1);
      seen_u |= unlock; seen_r |= key_ready;
    end
    for (int i = 0; i < 30; i++) begin
      cyc(0, 8'h00, i[0]);
      seen_u |= unlock; seen_r |= key_ready;
    end
    chk("lo.unlock_seen", int'(seen_u), 0);
    chk("lo.ready_seen", int'(seen_r), 0);
    chk("lo.fail_hold", int'(fail_cnt), 3);
    chk("lo.lockout_hold", int'(lockout), 1);
    do_reset();
    chk("lo.reset_lockout", int'(lockout), 0);
    chk("lo.reset_fail", int'(fail_cnt), 0);

    // Reset after two bytes discards the partial key.
    cyc(1, 8'hA5, 1);
    cyc(1, 8'h5A, 1);
    @(negedge clk);
    resetn = 1'b1;
    key_valid = 1'b0;
    #1;
    chk("rst.ready", int'(key_ready), 1);
    chk("rst.unlock", int'(unlock), 0);
    @(negedge clk);
    resetn = 1'b0;
    key_with_ack(n);
    chk("rst.unlock_cycles", n, 3);
    chk("rst.fail", int'(fail_cnt), 0);
    chk("rst.ready_end", int'(key_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
